pipeline_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the in-order MIPS pipeline, generalising the fixed EX/MEM/WB forwarding unit to a configurable number of tracked producer stages. It keeps a shift-register scoreboard of in-flight destination registers. From that scoreboard it generates:
- load-use and branch-operand stalls;
- IF/ID flush on taken branches;
- per-operand forwarding selects for the instruction in ID.

It sits beside the ID stage, driving the IF/ID write enable, the IF/ID flush and the ID/EX bubble insertion.

---
 rtl/pipeline_scoreboard.sv | 146 ++++++++++++++
 tb/tb_pipeline_scoreboard.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard
//   Hazard and forwarding controller for the in-order pipeline. A shift
//   register of DEPTH slots follows each instruction's destination after it
//   leaves ID (slot 1 = EX ... slot DEPTH = WB). From those slots it derives
//   load-use and branch-operand stalls, the IF/ID flush for taken branches,
//   and per-operand forwarding selects for the instruction in ID.
//
//   Ports
//     clock, reset      rising-edge clock, asynchronous active-low reset
//     id_*              decoded fields of the instruction currently in ID
//     branch_taken      ID branch comparison result
//     stall             hold PC and IF/ID, inject a bubble into ID/EX
//     flush             clear IF/ID
//     fwd_sel_rs/rt     0 = register file, k = result of producer stage k
//     stage_busy        valid bit of each slot (bit k-1 = slot k)
//     stall_count,      saturating event counters, present only when
//     flush_count       PIPELINE_SCOREBOARD_PERF_EN is defined
module pipeline_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_branch,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  flush,
    output logic [SEL_W-1:0]      fwd_sel_rs,
    output logic [SEL_W-1:0]      fwd_sel_rt,
    output logic [DEPTH-1:0]      stage_busy
`ifdef PIPELINE_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           flush_count
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  memRead;
    } SlotEntry;

    SlotEntry         slots [1:DEPTH];
    SlotEntry         entry;
    logic [DEPTH:1]   matchRs;
    logic [DEPTH:1]   matchRt;
    logic             loadUse;
    logic             branchStall;
    logic             stallInt;

    // A stalled instruction stays in ID, so a bubble enters slot 1 instead.
    always_comb begin
        entry          = '0;
        entry.valid    = id_valid & ~stallInt;
        entry.rd       = id_rd;
        entry.regWrite = id_reg_write;
        entry.memRead  = id_mem_read;
    end

    // NOTE: the slots are a handful of flops, not a RAM, so resetting every
    // entry asynchronously is cheap and makes stage_busy clear immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) slots[k] <= '0;
        end else begin
            slots[1] <= entry;
            for (int k = 2; k <= DEPTH; k++) slots[k] <= slots[k-1];
        end
    end

    // Register 0 is hard-wired, so a producer targeting it never matches.
    // NOTE: combinational blocks use blocking assignments and give every
    // output a value on every path, which keeps latches from being inferred.
    always_comb begin
        matchRs = '0;
        matchRt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            matchRs[k] = slots[k].valid & slots[k].regWrite & (slots[k].rd != '0)
                       & (slots[k].rd == id_rs) & id_use_rs & id_valid;
            matchRt[k] = slots[k].valid & slots[k].regWrite & (slots[k].rd != '0)
                       & (slots[k].rd == id_rt) & id_use_rt & id_valid;
        end
    end

    // A load result is usable from slot 2 on. A branch compares in ID, one
    // stage earlier than the ALU, so it also waits out an ALU producer in
    // slot 1 and a load in slot 2.
    assign loadUse     = (matchRs[1] | matchRt[1]) & slots[1].memRead;
    assign branchStall = id_branch & ((matchRs[1] | matchRt[1])
                       | ((matchRs[2] | matchRt[2]) & slots[2].memRead));
    assign stallInt    = loadUse | branchStall;

    // Slots are already clear during reset; flush depends on ID inputs alone
    // and must be masked explicitly.
    assign stall = stallInt & reset;
    assign flush = reset & id_valid & id_branch & branch_taken & ~stallInt;

    // Scan oldest to youngest so the youngest producer overwrites the select.
    always_comb begin
        fwd_sel_rs = '0;
        fwd_sel_rt = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (matchRs[k]) fwd_sel_rs = SEL_W'(k);
            if (matchRt[k]) fwd_sel_rt = SEL_W'(k);
        end
        if (stallInt) begin
            fwd_sel_rs = '0;
            fwd_sel_rt = '0;
        end
    end

    always_comb begin
        stage_busy = '0;
        for (int k = 1; k <= DEPTH; k++) stage_busy[k-1] = slots[k].valid;
    end

`ifdef PIPELINE_SCOREBOARD_PERF_EN
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (stall && stallCount != '1) stallCount <= stallCount + 32'd1;
            if (flush && flushCount != '1) flushCount <= flushCount + 32'd1;
        end
    end

    assign stall_count = stallCount;
    assign flush_count = flushCount;
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Testbench for pipeline_scoreboard. Two instances (DEPTH=3/5-bit registers
// and DEPTH=5/6-bit registers) receive the same instruction stream. Register
// numbers are drawn from a set whose low five bits are distinct, so both
// instances see identical hazards while exercising register 63 on the wide one.
// Expected values come from a history of what entered the pipeline d cycles
// ago and the rule "a result is usable once it is old enough".
module tb_pipeline_scoreboard;

    typedef struct packed {
        logic       v;
        logic [5:0] rs;
        logic [5:0] rt;
        logic       us;
        logic       ut;
        logic [5:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic       tk;
    } instr_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] rd;
        logic       rw;
        logic       mr;
    } hist_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    instr_t     cur   = '0;

    logic       stallA, flushA, stallB, flushB;
    logic [1:0] selRsA, selRtA;
    logic [2:0] selRsB, selRtB;
    logic [2:0] busyA;
    logic [4:0] busyB;
`ifdef PIPELINE_SCOREBOARD_PERF_EN
    logic [31:0] stallCntA, flushCntA, stallCntB, flushCntB;
`endif

    hist_t      hist [8];
    logic       curStall, curFlush;
    int         modelStalls, modelFlushes;
    int         checks = 0;
    int         errors = 0;
    logic [5:0] regSet [6] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd63};

    always #5 clock = ~clock;

    pipeline_scoreboard dutA (
        .clock(clock), .reset(reset), .id_valid(cur.v),
        .id_rs(cur.rs[4:0]), .id_rt(cur.rt[4:0]),
        .id_use_rs(cur.us), .id_use_rt(cur.ut), .id_rd(cur.rd[4:0]),
        .id_reg_write(cur.rw), .id_mem_read(cur.mr),
        .id_branch(cur.br), .branch_taken(cur.tk),
        .stall(stallA), .flush(flushA),
        .fwd_sel_rs(selRsA), .fwd_sel_rt(selRtA), .stage_busy(busyA)
`ifdef PIPELINE_SCOREBOARD_PERF_EN
        , .stall_count(stallCntA), .flush_count(flushCntA)
`endif
    );

    pipeline_scoreboard #(.DEPTH(5), .REG_ADDR_W(6)) dutB (
        .clock(clock), .reset(reset), .id_valid(cur.v),
        .id_rs(cur.rs), .id_rt(cur.rt),
        .id_use_rs(cur.us), .id_use_rt(cur.ut), .id_rd(cur.rd),
        .id_reg_write(cur.rw), .id_mem_read(cur.mr),
        .id_branch(cur.br), .branch_taken(cur.tk),
        .stall(stallB), .flush(flushB),
        .fwd_sel_rs(selRsB), .fwd_sel_rt(selRtB), .stage_busy(busyB)
`ifdef PIPELINE_SCOREBOARD_PERF_EN
        , .stall_count(stallCntB), .flush_count(flushCntB)
`endif
    );

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic producedBy(input int d, input logic [5:0] src, input logic useSrc);
        return cur.v && useSrc && src != 6'd0 && hist[d-1].valid
               && hist[d-1].rw && hist[d-1].rd == src;
    endfunction

    // A result is usable by an ALU consumer 1 cycle after issue (2 for a
    // load); a branch needs it one cycle later still.
    function automatic logic modelStall(input int depth);
        logic s = 1'b0;
        for (int d = 1; d <= depth; d++) begin
            int ready = (hist[d-1].mr ? 2 : 1) + (cur.br ? 1 : 0);
            if (d < ready && (producedBy(d, cur.rs, cur.us) || producedBy(d, cur.rt, cur.ut)))
                s = 1'b1;
        end
        return s;
    endfunction

    function automatic int modelFwd(input int depth, input logic [5:0] src, input logic useSrc);
        if (modelStall(depth)) return 0;
        for (int d = 1; d <= depth; d++)
            if (producedBy(d, src, useSrc)) return d;
        return 0;
    endfunction

    function automatic int modelBusy(input int depth);
        int b = 0;
        for (int d = 1; d <= depth; d++) if (hist[d-1].valid) b |= (1 << (d - 1));
        return b;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 8; i++) hist[i] = '0;
        modelStalls  = 0;
        modelFlushes = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic instr_t mkNop();
        return '0;
    endfunction

    function automatic instr_t mkAlu(input logic [5:0] rd, rs, rt);
        instr_t i = '0;
        i.v = 1'b1; i.rs = rs; i.rt = rt; i.us = 1'b1; i.ut = 1'b1; i.rd = rd; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t mkLw(input logic [5:0] rt, base);
        instr_t i = '0;
        i.v = 1'b1; i.rs = base; i.us = 1'b1; i.rd = rt; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic instr_t mkBeq(input logic [5:0] rs, rt, input logic taken);
        instr_t i = '0;
        i.v = 1'b1; i.rs = rs; i.rt = rt; i.us = 1'b1; i.ut = 1'b1; i.br = 1'b1; i.tk = taken;
        return i;
    endfunction

    // Present an instruction in ID and compare every combinational output.
    task automatic issue(input instr_t i);
        cur = i;
        #2;
        curStall = modelStall(3);
        curFlush = cur.v && cur.br && cur.tk && !curStall;
        check("stallA", stallA, curStall);
        check("stallB", stallB, modelStall(5));
        check("flushA", flushA, curFlush);
        check("flushB", flushB, curFlush);
        check("fwdRsA", selRsA, modelFwd(3, cur.rs, cur.us));
        check("fwdRtA", selRtA, modelFwd(3, cur.rt, cur.ut));
        check("fwdRsB", selRsB, modelFwd(5, cur.rs, cur.us));
        check("fwdRtB", selRtB, modelFwd(5, cur.rt, cur.ut));
        check("busyA", busyA, modelBusy(3));
        check("busyB", busyB, modelBusy(5));
`ifdef PIPELINE_SCOREBOARD_PERF_EN
        check("stallCnt", stallCntA, modelStalls);
        check("flushCnt", flushCntB, modelFlushes);
`endif
    endtask

    // Clock edge: the instruction in ID enters the pipeline unless stalled.
    task automatic tick();
        hist_t e = '0;
        @(posedge clock);
        if (cur.v && !curStall) begin
            e.valid = 1'b1; e.rd = cur.rd; e.rw = cur.rw; e.mr = cur.mr;
        end
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = e;
        if (curStall) modelStalls++;
        if (curFlush) modelFlushes++;
        #1;
    endtask

    task automatic step(input instr_t i);
        issue(i);
        tick();
    endtask

    task automatic drain(input int n);
        repeat (n) step(mkNop());
    endtask

    initial begin
        int cnt0;
        instr_t r;
        clearModel();
        curStall = 1'b0;
        curFlush = 1'b0;

        // Reset state.
        #2;
        check("rst_stall", stallA, 0);
        check("rst_busyA", busyA, 0);
        check("rst_busyB", busyB, 0);
        #10 reset = 1'b1;   // released at t=12, between edges

        // lw $2 ; add $3,$2,$4
        step(mkLw(6'd2, 6'd1));
        issue(mkAlu(6'd3, 6'd2, 6'd4));
        check("lu_stall", stallA, 1);
        tick();
        check("lu_bubble", busyA[0], 0);
        issue(mkAlu(6'd3, 6'd2, 6'd4));
        check("lu_nostall", stallA, 0);
        check("lu_fwd2", selRsA, 2);
        tick();
        drain(6);

        // Forwarding distance 1..4 for sub $6,$5,$5 after add $5,$1,$1.
        for (int d = 1; d <= 4; d++) begin
            step(mkAlu(6'd5, 6'd1, 6'd1));
            repeat (d - 1) step(mkAlu(6'd10, 6'd11, 6'd12));
            issue(mkAlu(6'd6, 6'd5, 6'd5));
            check("dist_rsA", selRsA, (d <= 3) ? d : 0);
            check("dist_rtA", selRtA, (d <= 3) ? d : 0);
            check("dist_rsB", selRsB, d);
            tick();
            drain(6);
        end

        // Youngest producer wins; register 0 never forwards or stalls.
        step(mkAlu(6'd7, 6'd1, 6'd1));
        step(mkAlu(6'd10, 6'd1, 6'd1));
        step(mkAlu(6'd7, 6'd1, 6'd1));
        issue(mkAlu(6'd8, 6'd7, 6'd7));
        check("young_wins", selRsA, 1);
        tick();
        drain(6);
        step(mkLw(6'd0, 6'd1));
        step(mkAlu(6'd10, 6'd1, 6'd1));
        step(mkLw(6'd0, 6'd1));
        issue(mkBeq(6'd0, 6'd0, 1'b1));
        check("r0_stall", stallA, 0);
        check("r0_fwd", selRsA, 0);
        check("r0_flush", flushA, 1);
        tick();
        drain(6);

        // lw $8 ; beq $8,$9 taken: two stall cycles, then one flush.
        step(mkLw(6'd8, 6'd1));
        for (int c = 0; c < 2; c++) begin
            issue(mkBeq(6'd8, 6'd9, 1'b1));
            check("br_stall", stallA, 1);
            check("br_noflush", flushA, 0);
            tick();
        end
        issue(mkBeq(6'd8, 6'd9, 1'b1));
        check("br_go", stallA, 0);
        check("br_flush", flushA, 1);
        tick();
        issue(mkAlu(6'd10, 6'd1, 6'd1));
        check("br_flush_once", flushA, 0);
        tick();
        drain(6);

        // Reset in the middle of a load-use stall, with a taken branch in ID.
        step(mkLw(6'd2, 6'd1));
        issue(mkAlu(6'd3, 6'd2, 6'd4));
        check("mid_stall", stallA, 1);
        reset = 1'b0;
        cur.br = 1'b1;
        cur.tk = 1'b1;
        #1;
        check("rst_now_stall", stallA, 0);
        check("rst_now_flush", flushB, 0);
        check("rst_now_busyA", busyA, 0);
        check("rst_now_busyB", busyB, 0);
        check("rst_now_fwd", selRsA, 0);
        clearModel();
        curStall = 1'b0;
        curFlush = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        cur = '0;
`ifdef PIPELINE_SCOREBOARD_PERF_EN
        check("rst_stallcnt", stallCntA, 0);
`endif

        // Register 63 producer on the wide instance, visible at slots 1..5.
        step(mkAlu(6'd63, 6'd1, 6'd1));
        for (int d = 1; d <= 5; d++) begin
            issue(mkAlu(6'd10, 6'd63, 6'd1));
            check("r63_fwdB", selRsB, d);
            tick();
        end
        drain(6);

        // Ten load-use pairs each cost exactly one stall.
        cnt0 = modelStalls;
        for (int n = 0; n < 10; n++) begin
            step(mkLw(6'd2, 6'd1));
            issue(mkAlu(6'd3, 6'd2, 6'd2));
            tick();
            step(mkAlu(6'd3, 6'd2, 6'd2));
        end
        check("ten_stalls", modelStalls - cnt0, 10);
`ifdef PIPELINE_SCOREBOARD_PERF_EN
        issue(mkNop());
        check("perf_ten", stallCntB, cnt0 + 10);
        tick();
`endif
        drain(6);

        // Randomized stream; a stalled instruction is held in ID.
        r = mkNop();
        for (int c = 0; c < 400; c++) begin
            if (!curStall) begin
                int kind = $urandom_range(0, 9);
                logic [5:0] a = regSet[$urandom_range(0, 5)];
                logic [5:0] b = regSet[$urandom_range(0, 5)];
                logic [5:0] d = regSet[$urandom_range(0, 5)];
                if (kind == 0)      r = mkNop();
                else if (kind <= 2) r = mkLw(d, a);
                else if (kind <= 4) r = mkBeq(a, b, 1'($urandom_range(0, 1)));
                else begin
                    r = mkAlu(d, a, b);
                    r.ut = ($urandom_range(0, 3) != 0);
                end
            end
            step(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
